spi_arb: RTL

SPI_ARB -- requirements
Module: spi_arb

---
 rtl/spi_arb_pkg.sv | 10 +
 rtl/spi_arb_rr_arb2.sv | 12 +
 rtl/spi_arb.sv | 95 +++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state encoding, timeout length and requester indices for the SPI arbiter
package spi_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LOCKED} state_t;
    localparam int TIMEOUT_CYC = 1023;
    localparam int REQ_INERT = 0;
    localparam int REQ_A2D = 1;
    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/spi_arb_rr_arb2.sv
// rr_arb2: two-way round-robin winner select; the pointer breaks ties only
module rr_arb2
    import spi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       winner,
    output logic       any
);
    assign any    = |req;
    assign winner = (&req) ? rr_ptr : req[REQ_A2D];
endmodule

// File: rtl/spi_arb.sv
// spi_arb: shares one SPI_mstr16 between the inertial and A2D requesters with lock and timeout
module spi_arb
    import spi_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  lock,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    output logic [1:0]  gnt,
    output logic [1:0]  done_o,
    output logic [15:0] rd_data_o,
    output logic        err_o,
    output logic [1:0]  cs_sel,
    output logic        m_wrt,
    output logic [15:0] m_cmd,
    input  logic        m_done,
    input  logic [15:0] m_rd_data
);
    state_t      state, state_nxt;
    logic        owner, owner_nxt, rr_ptr, rr_nxt;
    logic        winner, any_req;
    logic [9:0]  cnt;
    logic        done_evt, timeout;

    rr_arb2 u_rr (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .any    (any_req)
    );

    // m_done wins over a timeout landing in the same cycle
    assign done_evt = (state == WAIT) && m_done;
    assign timeout  = (state == WAIT) && !m_done && (cnt == 10'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_nxt = winner;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (done_evt) begin
                    state_nxt = lock[owner] ? LOCKED : IDLE;
                    rr_nxt    = lock[owner] ? rr_ptr : ~owner;
                end else if (timeout) begin
                    state_nxt = IDLE;
                    rr_nxt    = ~owner;
                end
            end
            LOCKED: begin
                if (req[owner]) begin
                    state_nxt = ISSUE;
                end else if (!lock[owner]) begin
                    state_nxt = IDLE;
                    rr_nxt    = ~owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            rr_ptr    <= 1'b0;
            cnt       <= 10'd0;
            done_o    <= 2'b00;
            err_o     <= 1'b0;
            rd_data_o <= 16'h0000;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_nxt;
            cnt       <= (state == ISSUE) ? 10'd0 : (state == WAIT) ? cnt + 10'd1 : cnt;
            done_o    <= done_evt ? onehot(owner) : 2'b00;
            err_o     <= timeout;
            rd_data_o <= done_evt ? m_rd_data : rd_data_o;
        end
    end

    assign m_wrt  = (state == ISSUE);
    assign m_cmd  = m_wrt ? ((owner == 1'(REQ_A2D)) ? cmd1 : cmd0) : 16'h0000;
    assign gnt    = m_wrt ? onehot(owner) : 2'b00;
    assign cs_sel = (state == IDLE) ? 2'b00 : onehot(owner);
endmodule
